// File: rtl/seq_arith_unit.sv
// Multi-cycle unsigned arithmetic unit: single-cycle add/sub, iterative shift-add multiply
// and restoring divide (one bit per cycle), with valid/ready handshakes on both sides.
module seq_arith_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             carry,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_reg, state_next;
  logic             is_div_reg, is_div_next;
  logic [WIDTH-1:0] opb_reg, opb_next;
  // hi/lo hold accumulator+multiplier for mul, partial remainder+dividend/quotient for div
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] res_lo_reg, res_lo_next;
  logic [WIDTH-1:0] res_hi_reg, res_hi_next;
  logic             carry_reg, carry_next;
  logic             div_zero_reg, div_zero_next;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_diff;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic             div_fit;
  logic [WIDTH-1:0] hi_step;
  logic [WIDTH-1:0] lo_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      is_div_reg   <= 1'b0;
      opb_reg      <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      cnt_reg      <= '0;
      res_lo_reg   <= '0;
      res_hi_reg   <= '0;
      carry_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      is_div_reg   <= is_div_next;
      opb_reg      <= opb_next;
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
      cnt_reg      <= cnt_next;
      res_lo_reg   <= res_lo_next;
      res_hi_reg   <= res_hi_next;
      carry_reg    <= carry_next;
      div_zero_reg <= div_zero_next;
    end
  end

  always_comb begin
    add_sum   = {1'b0, a} + {1'b0, b};
    sub_diff  = {1'b0, a} - {1'b0, b};
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opb_reg} : '0);
    // Remainder stays below the divisor, so bit WIDTH of the trial is a clean borrow flag
    div_shift = {hi_reg, lo_reg[WIDTH-1]};
    div_trial = div_shift - {1'b0, opb_reg};
    div_fit   = ~div_trial[WIDTH];
    if (is_div_reg) begin
      hi_step = div_fit ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
      lo_step = {lo_reg[WIDTH-2:0], div_fit};
    end else begin
      hi_step = mul_sum[WIDTH:1];
      lo_step = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_next    = state_reg;
    is_div_next   = is_div_reg;
    opb_next      = opb_reg;
    hi_next       = hi_reg;
    lo_next       = lo_reg;
    cnt_next      = cnt_reg;
    res_lo_next   = res_lo_reg;
    res_hi_next   = res_hi_reg;
    carry_next    = carry_reg;
    div_zero_next = div_zero_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          is_div_next = op[0];
          opb_next    = b;
          hi_next     = '0;
          lo_next     = a;
          case (op)
            2'b00: begin
              res_lo_next   = add_sum[WIDTH-1:0];
              res_hi_next   = '0;
              carry_next    = add_sum[WIDTH];
              div_zero_next = 1'b0;
              state_next    = DONE;
            end
            2'b01: begin
              res_lo_next   = sub_diff[WIDTH-1:0];
              res_hi_next   = '0;
              carry_next    = sub_diff[WIDTH];
              div_zero_next = 1'b0;
              state_next    = DONE;
            end
            default: begin
              if (op[0] && (b == '0)) begin
                res_lo_next   = '1;
                res_hi_next   = a;
                carry_next    = 1'b0;
                div_zero_next = 1'b1;
                state_next    = DONE;
              end else begin
                cnt_next   = CW'(WIDTH);
                state_next = BUSY;
              end
            end
          endcase
        end
      end
      BUSY: begin
        hi_next  = hi_step;
        lo_next  = lo_step;
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CW'(1)) begin
          res_lo_next   = lo_step;
          res_hi_next   = hi_step;
          carry_next    = 1'b0;
          div_zero_next = 1'b0;
          state_next    = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign res_lo    = res_lo_reg;
  assign res_hi    = res_hi_reg;
  assign carry     = carry_reg;
  assign div_zero  = div_zero_reg;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Bench for seq_arith_unit at WIDTH=8 and WIDTH=16: directed cases pinned to literals,
// then randomized ops scored against a plain-arithmetic model.
module tb_seq_arith_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit done_flags [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Directed cases: add, sub, sub(borrow), mul, div, div-by-zero, div after reset
  localparam int D_OP   [7] = '{0, 1, 1, 2, 3, 3, 3};
  localparam int D_A8   [7] = '{200, 15, 3, 100, 25, 50, 100};
  localparam int D_B8   [7] = '{100, 7, 5, 25, 3, 0, 25};
  localparam int D_LO8  [7] = '{44, 8, 254, 196, 8, 255, 4};
  localparam int D_HI8  [7] = '{0, 0, 0, 9, 1, 50, 0};
  localparam int D_C8   [7] = '{1, 0, 1, 0, 0, 0, 0};
  localparam int D_LAT8 [7] = '{1, 1, 1, 9, 9, 1, 9};
  localparam int D_A16  [7] = '{65535, 0, 1000, 65535, 65535, 65535, 100};
  localparam int D_B16  [7] = '{1, 1, 1000, 255, 255, 0, 25};
  localparam int D_LO16 [7] = '{0, 65535, 0, 65281, 257, 65535, 4};
  localparam int D_HI16 [7] = '{0, 0, 0, 254, 0, 65535, 0};
  localparam int D_C16  [7] = '{1, 1, 0, 0, 0, 0, 0};
  localparam int D_LAT16[7] = '{1, 1, 1, 17, 17, 1, 17};
  localparam int D_DZ   [7] = '{0, 0, 0, 0, 0, 1, 0};

  for (genvar gi = 0; gi < 2; gi++) begin : g_w
    localparam int W = (gi == 0) ? 8 : 16;

    logic         rst, in_valid, in_ready, out_valid, out_ready, carry, div_zero;
    logic [1:0]   op;
    logic [W-1:0] a, b, res_lo, res_hi;
    logic [W-1:0] exp_lo, exp_hi;
    logic         exp_c, exp_dz;
    logic         exp_pending = 1'b0;

    seq_arith_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .res_lo(res_lo), .res_hi(res_hi), .carry(carry), .div_zero(div_zero)
    );

    function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] lo, output logic [W-1:0] hi,
                                  output logic c, output logic dz, output int lat);
      longint unsigned xa, ya, r;
      xa = 64'(x);
      ya = 64'(y);
      lo = '0; hi = '0; c = 1'b0; dz = 1'b0; lat = 1;
      case (o)
        2'd0: begin r = xa + ya; lo = W'(r); c = (r >> W) != 0; end
        2'd1: begin r = xa - ya; lo = W'(r); c = xa < ya; end
        2'd2: begin r = xa * ya; lo = W'(r); hi = W'(r >> W); lat = W + 1; end
        default: begin
          if (ya == 0) begin lo = '1; hi = x; dz = 1'b1; end
          else begin lo = W'(xa / ya); hi = W'(xa % ya); lat = W + 1; end
        end
      endcase
    endfunction

    // Every cycle: never ready and valid together; a presented result must match the model
    always @(negedge clk) begin
      if (!rst) begin
        chk($sformatf("w%0d ready_with_valid", W), 64'(in_ready & out_valid), 64'(0));
        if (out_valid && exp_pending) begin
          chk($sformatf("w%0d res_lo", W), 64'(res_lo), 64'(exp_lo));
          chk($sformatf("w%0d res_hi", W), 64'(res_hi), 64'(exp_hi));
          chk($sformatf("w%0d carry", W), 64'(carry), 64'(exp_c));
          chk($sformatf("w%0d div_zero", W), 64'(div_zero), 64'(exp_dz));
        end else if (out_valid) begin
          chk($sformatf("w%0d spurious_out_valid", W), 64'(out_valid), 64'(exp_pending));
        end
      end
    end

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int hold);
      int n, lat;
      logic [W-1:0] lo, hi;
      logic c, dz;
      n = 0;
      while (!in_ready && n < 4 * W) begin @(posedge clk); #1; n++; end
      chk($sformatf("w%0d idle_wait", W), 64'(in_ready), 64'(1));
      in_valid = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      in_valid = 1'b0; op = 2'($urandom); a = W'($urandom); b = W'($urandom);
      model(o, x, y, lo, hi, c, dz, lat);
      exp_lo = lo; exp_hi = hi; exp_c = c; exp_dz = dz; exp_pending = 1'b1;
      n = 1;
      while (!out_valid && n < 3 * W) begin
        chk($sformatf("w%0d busy_in_ready", W), 64'(in_ready), 64'(0));
        in_valid = 1'($urandom);
        @(posedge clk); #1;
        n++;
      end
      in_valid = 1'b0;
      chk($sformatf("w%0d latency", W), 64'(n), 64'(lat));
      for (int k = 0; k < hold; k++) begin
        in_valid = 1'($urandom); op = 2'($urandom); a = W'($urandom);
        @(posedge clk); #1;
        chk($sformatf("w%0d held_out_valid", W), 64'(out_valid), 64'(1));
      end
      $display("w%0d op=%0d a=%0h b=%0h -> lo=%0h hi=%0h c=%0b dz=%0b lat=%0d hold=%0d",
               W, o, x, y, res_lo, res_hi, carry, div_zero, n, hold);
      // Release with a competing in_valid: it must not be taken in the same cycle
      in_valid = 1'b1; out_ready = 1'b1; op = 2'($urandom);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0; exp_pending = 1'b0;
      chk($sformatf("w%0d release_out_valid", W), 64'(out_valid), 64'(0));
      chk($sformatf("w%0d release_in_ready", W), 64'(in_ready), 64'(1));
    endtask

    task automatic check_reset_state(input string tag);
      chk($sformatf("w%0d %s res_lo", W, tag), 64'(res_lo), 64'(0));
      chk($sformatf("w%0d %s res_hi", W, tag), 64'(res_hi), 64'(0));
      chk($sformatf("w%0d %s carry", W, tag), 64'(carry), 64'(0));
      chk($sformatf("w%0d %s div_zero", W, tag), 64'(div_zero), 64'(0));
      chk($sformatf("w%0d %s out_valid", W, tag), 64'(out_valid), 64'(0));
      chk($sformatf("w%0d %s in_ready", W, tag), 64'(in_ready), 64'(1));
    endtask

    initial begin
      logic [1:0]   o;
      logic [W-1:0] x, y, lo, hi;
      logic         c, dz;
      int           lat;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset");
      @(negedge clk) rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
        o = 2'(D_OP[i]);
        x = W'((W == 8) ? D_A8[i] : D_A16[i]);
        y = W'((W == 8) ? D_B8[i] : D_B16[i]);
        model(o, x, y, lo, hi, c, dz, lat);
        chk($sformatf("w%0d pin%0d lo", W, i), 64'(lo), 64'((W == 8) ? D_LO8[i] : D_LO16[i]));
        chk($sformatf("w%0d pin%0d hi", W, i), 64'(hi), 64'((W == 8) ? D_HI8[i] : D_HI16[i]));
        chk($sformatf("w%0d pin%0d c", W, i), 64'(c), 64'((W == 8) ? D_C8[i] : D_C16[i]));
        chk($sformatf("w%0d pin%0d dz", W, i), 64'(dz), 64'(D_DZ[i]));
        chk($sformatf("w%0d pin%0d lat", W, i), 64'(lat), 64'((W == 8) ? D_LAT8[i] : D_LAT16[i]));
        if (i == 6) begin
          // Abort a multiply with four iterations left
          in_valid = 1'b1; op = 2'd2; a = W'($urandom); b = W'($urandom);
          @(posedge clk); #1;
          in_valid = 1'b0;
          repeat (W - 4) @(posedge clk);
          #1;
          rst = 1'b1; exp_pending = 1'b0;
          #1;
          check_reset_state("midmul_reset");
          @(negedge clk) rst = 1'b0;
        end
        run_op(o, x, y, (i == 3) ? 5 : 1);
      end

      for (int i = 0; i < 60; i++) begin
        o = 2'($urandom);
        x = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
        y = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
        run_op(o, x, y, int'($urandom_range(0, 3)));
      end
      done_flags[gi] = 1'b1;
    end
  end

  initial begin
    wait (done_flags[0] && done_flags[1]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
